// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the scanning N:1 multiplexer slice.
//   mux_state_e : controller state encoding (MAN = manual, SCAN = automatic)
//   clog2       : ceiling log2 used to size channel-index and counter signals
// ---------------------------------------------------------------------------
package mux_pkg;

  typedef enum logic {
    MAN  = 1'b0,
    SCAN = 1'b1
  } mux_state_e;

  // Ceiling log2 for elaboration-time sizing; clog2(1) is 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_sel_nx1.sv
// ---------------------------------------------------------------------------
// mux_sel_nx1
// Purely combinational N:1 channel selector.
//   data_in : N packed channels, channel k at bits [k*W +: W]
//   sel     : channel index
//   y       : selected channel, or all zeros when sel >= N
// ---------------------------------------------------------------------------
module mux_sel_nx1
  import mux_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 1,
  localparam int SW = clog2(N)
) (
  input  logic [N*W-1:0] data_in,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   y
);

  // Unmatched indices (only possible when N is not a power of two) fall
  // through to the zero default.
  always_comb begin
    y = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(sel) == k) begin
        y = data_in[k*W +: W];
      end
    end
  end

endmodule

// File: rtl/mux_scan_nx1.sv
// ---------------------------------------------------------------------------
// mux_scan_nx1
// Registered N:1 multiplexer with a manual-select mode and an automatic
// scan mode that dwells DWELL enabled cycles on each channel in turn.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : cycle enable; low freezes all state
//   mode       : 0 = manual select (sel), 1 = automatic scan
//   sel        : manual channel index (ignored while scanning)
//   data_in    : N packed channels of W bits
//   data_out   : registered selected channel data
//   ch_out     : index of the channel presented on data_out
//   valid_out  : data_out/ch_out were updated this cycle
//   wrap_out   : one-cycle pulse when the scan comes back to channel 0
// ---------------------------------------------------------------------------
module mux_scan_nx1
  import mux_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int W     = 1,
  parameter  int DWELL = 4,
  localparam int SW    = clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N*W-1:0] data_in,
  output logic [W-1:0]   data_out,
  output logic [SW-1:0]  ch_out,
  output logic           valid_out,
  output logic           wrap_out
);

  // A DWELL of 1 needs no real counter, but keep at least one bit.
  localparam int DW_W = (DWELL > 1) ? clog2(DWELL) : 1;

  mux_state_e      state_q,     state_d;
  logic [SW-1:0]   ch_cnt_q,    ch_cnt_d;
  logic [DW_W-1:0] dwell_q,     dwell_d;
  logic            wrap_pend_q, wrap_pend_d;
  logic [W-1:0]    data_out_q,  data_out_d;
  logic [SW-1:0]   ch_out_q,    ch_out_d;
  logic            valid_q,     valid_d;
  logic            wrap_q,      wrap_d;

  logic [SW-1:0]   mux_idx;
  logic [W-1:0]    mux_y;

  // The channel presented this cycle follows the state held before the edge.
  assign mux_idx = (state_q == SCAN) ? ch_cnt_q : sel;

  mux_sel_nx1 #(
    .N (N),
    .W (W)
  ) u_sel (
    .data_in (data_in),
    .sel     (mux_idx),
    .y       (mux_y)
  );

  // Next-state logic. wrap_pend remembers that the channel counter has just
  // rolled over, so the pulse lines up with channel 0 actually appearing on
  // ch_out, even if an enable gap falls in between.
  always_comb begin
    state_d     = state_q;
    ch_cnt_d    = ch_cnt_q;
    dwell_d     = dwell_q;
    wrap_pend_d = wrap_pend_q;
    data_out_d  = data_out_q;
    ch_out_d    = ch_out_q;
    valid_d     = 1'b0;
    wrap_d      = 1'b0;

    if (en) begin
      state_d    = mode ? SCAN : MAN;
      data_out_d = mux_y;
      ch_out_d   = mux_idx;

      if (state_q == MAN) begin
        valid_d     = (int'(sel) < N);
        ch_cnt_d    = '0;
        dwell_d     = '0;
        wrap_pend_d = 1'b0;
      end else begin
        valid_d     = 1'b1;
        wrap_d      = wrap_pend_q;
        wrap_pend_d = 1'b0;
        if (int'(dwell_q) == DWELL - 1) begin
          dwell_d = '0;
          if (int'(ch_cnt_q) == N - 1) begin
            ch_cnt_d    = '0;
            wrap_pend_d = 1'b1;
          end else begin
            ch_cnt_d = ch_cnt_q + SW'(1);
          end
        end else begin
          dwell_d = dwell_q + DW_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MAN;
      ch_cnt_q    <= '0;
      dwell_q     <= '0;
      wrap_pend_q <= 1'b0;
      data_out_q  <= '0;
      ch_out_q    <= '0;
      valid_q     <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_cnt_q    <= ch_cnt_d;
      dwell_q     <= dwell_d;
      wrap_pend_q <= wrap_pend_d;
      data_out_q  <= data_out_d;
      ch_out_q    <= ch_out_d;
      valid_q     <= valid_d;
      wrap_q      <= wrap_d;
    end
  end

  assign data_out  = data_out_q;
  assign ch_out    = ch_out_q;
  assign valid_out = valid_q;
  assign wrap_out  = wrap_q;

endmodule

// File: tb/tb_mux_scan_nx1.sv
// ---------------------------------------------------------------------------
// tb_mux_scan_nx1
// Self-checking bench for mux_scan_nx1. Three instances share clock, reset,
// enable and mode:
//   u0 : N=4, W=8, DWELL=2
//   u1 : N=3, W=4, DWELL=3 (non-power-of-two channel count)
//   u2 : N=2, W=2, DWELL=1
// A scan-position model (channel = position / DWELL mod N) predicts every
// output; a vector table and short hand sequences pin the documented cases.
// ---------------------------------------------------------------------------
module tb_mux_scan_nx1;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        mode;
  logic [1:0]  sel0;
  logic [1:0]  sel1;
  logic [0:0]  sel2;
  logic [31:0] d0;
  logic [11:0] d1;
  logic [3:0]  d2;

  logic [7:0]  dout0;
  logic [3:0]  dout1;
  logic [1:0]  dout2;
  logic [1:0]  ch0;
  logic [1:0]  ch1;
  logic [0:0]  ch2;
  logic        v0, v1, v2;
  logic        w0, w1, w2;

  int n_compared;
  int n_mismatched;

  // Model state per instance: scanning flag and scan position.
  logic        m_scan [3];
  int          m_p    [3];
  logic [31:0] e_data [3];
  logic [31:0] e_ch   [3];
  logic        e_valid[3];
  logic        e_wrap [3];

  typedef struct {
    logic       en;
    logic       mode;
    logic [1:0] sel;
    logic [7:0] exp_data;
    logic [1:0] exp_ch;
    logic       exp_valid;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[$];

  mux_scan_nx1 #(.N(4), .W(8), .DWELL(2)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel0), .data_in(d0),
    .data_out(dout0), .ch_out(ch0), .valid_out(v0), .wrap_out(w0));

  mux_scan_nx1 #(.N(3), .W(4), .DWELL(3)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel1), .data_in(d1),
    .data_out(dout1), .ch_out(ch1), .valid_out(v1), .wrap_out(w1));

  mux_scan_nx1 #(.N(2), .W(2), .DWELL(1)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel2), .data_in(d2),
    .data_out(dout2), .ch_out(ch2), .valid_out(v2), .wrap_out(w2));

  // 10-unit clock period, first rising edge at t=5.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the stimulus ever fails to finish.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish (got running, need finished)");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic en_i, input logic mode_i, input logic [1:0] s0,
                               input logic [1:0] s1, input logic s2);
    en   = en_i;
    mode = mode_i;
    sel0 = s0;
    sel1 = s1;
    sel2 = s2;
  endtask

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      m_scan[i]  = 1'b0;
      m_p[i]     = 0;
      e_data[i]  = '0;
      e_ch[i]    = '0;
      e_valid[i] = 1'b0;
      e_wrap[i]  = 1'b0;
    end
  endtask

  // One enabled/disabled clock of one instance, from the pre-edge inputs.
  task automatic modelStep(input int i, input int n, input int w, input int dw,
                           input logic [31:0] din, input int s);
    logic [31:0] mask;
    int c;
    mask = (32'd1 << w) - 32'd1;
    if (!en) begin
      e_valid[i] = 1'b0;
      e_wrap[i]  = 1'b0;
    end else if (!m_scan[i]) begin
      e_ch[i] = 32'(s);
      if (s < n) begin
        e_data[i]  = (din >> (s * w)) & mask;
        e_valid[i] = 1'b1;
      end else begin
        e_data[i]  = '0;
        e_valid[i] = 1'b0;
      end
      e_wrap[i] = 1'b0;
      m_p[i]    = 0;
      m_scan[i] = mode;
    end else begin
      c          = (m_p[i] / dw) % n;
      e_ch[i]    = 32'(c);
      e_data[i]  = (din >> (c * w)) & mask;
      e_valid[i] = 1'b1;
      e_wrap[i]  = (m_p[i] > 0) && (m_p[i] % (n * dw) == 0);
      m_p[i]     = m_p[i] + 1;
      m_scan[i]  = mode;
    end
  endtask

  task automatic checkAll();
    checkOutput("u0.data_out",  32'(dout0), e_data[0]);
    checkOutput("u0.ch_out",    32'(ch0),   e_ch[0]);
    checkOutput("u0.valid_out", 32'(v0),    32'(e_valid[0]));
    checkOutput("u0.wrap_out",  32'(w0),    32'(e_wrap[0]));
    checkOutput("u1.data_out",  32'(dout1), e_data[1]);
    checkOutput("u1.ch_out",    32'(ch1),   e_ch[1]);
    checkOutput("u1.valid_out", 32'(v1),    32'(e_valid[1]));
    checkOutput("u1.wrap_out",  32'(w1),    32'(e_wrap[1]));
    checkOutput("u2.data_out",  32'(dout2), e_data[2]);
    checkOutput("u2.ch_out",    32'(ch2),   e_ch[2]);
    checkOutput("u2.valid_out", 32'(v2),    32'(e_valid[2]));
    checkOutput("u2.wrap_out",  32'(w2),    32'(e_wrap[2]));
  endtask

  // Predict, clock once, then compare 1 unit after the rising edge.
  task automatic tick();
    modelStep(0, 4, 8, 2, d0, int'(sel0));
    modelStep(1, 3, 4, 3, 32'(d1), int'(sel1));
    modelStep(2, 2, 2, 1, 32'(d2), int'(sel2));
    @(posedge clk);
    #1;
    checkAll();
  endtask

  // Asynchronous reset pulse: outputs must clear with no clock edge.
  task automatic resetPulse();
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic void addVec(input logic e, input logic m, input logic [1:0] s,
                                 input logic [7:0] dat, input logic [1:0] ch,
                                 input logic v, input logic wr);
    vec_t t;
    t.en = e; t.mode = m; t.sel = s;
    t.exp_data = dat; t.exp_ch = ch; t.exp_valid = v; t.exp_wrap = wr;
    vecs.push_back(t);
  endfunction

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    d0 = 32'hD3C2_B1A0;
    d1 = 12'h987;
    d2 = 4'b1001;
    modelReset();

    // Manual select, then scan with DWELL=2, an enable gap at channel 1,
    // and a return to manual mode.
    addVec(1, 0, 2, 8'hC2, 2'd2, 1, 0);
    addVec(1, 0, 0, 8'hA0, 2'd0, 1, 0);
    addVec(1, 1, 3, 8'hD3, 2'd3, 1, 0);
    addVec(1, 1, 1, 8'hA0, 2'd0, 1, 0);
    addVec(1, 1, 1, 8'hA0, 2'd0, 1, 0);
    addVec(1, 1, 1, 8'hB1, 2'd1, 1, 0);
    addVec(1, 1, 1, 8'hB1, 2'd1, 1, 0);
    addVec(1, 1, 1, 8'hC2, 2'd2, 1, 0);
    addVec(1, 1, 1, 8'hC2, 2'd2, 1, 0);
    addVec(1, 1, 1, 8'hD3, 2'd3, 1, 0);
    addVec(1, 1, 1, 8'hD3, 2'd3, 1, 0);
    addVec(1, 1, 1, 8'hA0, 2'd0, 1, 1);
    addVec(1, 1, 1, 8'hA0, 2'd0, 1, 0);
    addVec(1, 1, 1, 8'hB1, 2'd1, 1, 0);
    addVec(0, 1, 2, 8'hB1, 2'd1, 0, 0);
    addVec(0, 1, 2, 8'hB1, 2'd1, 0, 0);
    addVec(0, 1, 2, 8'hB1, 2'd1, 0, 0);
    addVec(1, 1, 2, 8'hB1, 2'd1, 1, 0);
    addVec(1, 1, 2, 8'hC2, 2'd2, 1, 0);
    addVec(1, 0, 1, 8'hC2, 2'd2, 1, 0);
    addVec(1, 0, 1, 8'hB1, 2'd1, 1, 0);
    addVec(0, 0, 3, 8'hB1, 2'd1, 0, 0);

    // Reset state.
    #2;
    checkAll();
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k].en, vecs[k].mode, vecs[k].sel, 2'd0, 1'b0);
      tick();
      checkOutput($sformatf("vec%0d.data_out", k),  32'(dout0), 32'(vecs[k].exp_data));
      checkOutput($sformatf("vec%0d.ch_out", k),    32'(ch0),   32'(vecs[k].exp_ch));
      checkOutput($sformatf("vec%0d.valid_out", k), 32'(v0),    32'(vecs[k].exp_valid));
      checkOutput($sformatf("vec%0d.wrap_out", k),  32'(w0),    32'(vecs[k].exp_wrap));
    end

    // Reset mid-scan; after release the scan restarts at channel 0.
    applyStimulus(1'b1, 1'b1, 2'd0, 2'd0, 1'b0);
    for (int k = 0; k < 5; k++) tick();
    resetPulse();
    applyStimulus(1'b1, 1'b1, 2'd2, 2'd0, 1'b0);
    tick();
    tick();
    checkOutput("restart.ch_out", 32'(ch0), 32'd0);
    checkOutput("restart.valid_out", 32'(v0), 32'd1);

    // Out-of-range manual select on the 3-channel instance.
    applyStimulus(1'b1, 1'b0, 2'd1, 2'd3, 1'b1);
    tick();
    tick();
    checkOutput("oor.data_out", 32'(dout1), 32'd0);
    checkOutput("oor.valid_out", 32'(v1), 32'd0);
    checkOutput("oor.ch_out", 32'(ch1), 32'd3);
    applyStimulus(1'b1, 1'b1, 2'd1, 2'd3, 1'b1);
    tick();
    tick();
    checkOutput("oor_scan.ch_out", 32'(ch1), 32'd0);
    checkOutput("oor_scan.valid_out", 32'(v1), 32'd1);
    checkOutput("dw1_start.ch_out", 32'(ch2), 32'd0);

    // DWELL=1, N=2: alternate channels, wrap on every return to 0.
    for (int k = 1; k <= 4; k++) begin
      tick();
      checkOutput($sformatf("dw1_%0d.ch_out", k), 32'(ch2), 32'(k % 2));
      checkOutput($sformatf("dw1_%0d.wrap_out", k), 32'(w2), 32'((k % 2) == 0));
    end

    // Randomized traffic with occasional asynchronous resets.
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 11) == 0) mode = ~mode;
      en   = ($urandom_range(0, 9) < 8);
      sel0 = 2'($urandom);
      sel1 = 2'($urandom);
      sel2 = 1'($urandom);
      d0   = $urandom;
      d1   = 12'($urandom);
      d2   = 4'($urandom);
      tick();
      if ($urandom_range(0, 99) == 0) resetPulse();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
